// File: rtl/w_gray_ptr_sync_dec.sv
// Write-domain synchronizer for the Gray read pointer: N-flop chain, registered Gray->binary decode
// and per-cycle advance count. Optional Gray-violation checker enabled by `define W_GRAY_PTR_CHECK_EN.
module w_gray_ptr_sync_dec #(
  parameter int ADDR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_CNT_WIDTH = 4
) (
  input  logic                     w_clk,
  input  logic                     w_rst_n,
  input  logic [ADDR_WIDTH:0]      unsync_r_ptr,
  output logic [ADDR_WIDTH:0]      sync_gr_r_ptr,
  output logic [ADDR_WIDTH:0]      sync_bin_r_ptr,
  output logic [ADDR_WIDTH:0]      r_ptr_adv,
  output logic                     r_ptr_moved,
  input  logic                     gray_err_clr,
  output logic                     gray_err,
  output logic [ERR_CNT_WIDTH-1:0] gray_err_cnt
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("w_gray_ptr_sync_dec: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  function automatic logic [ADDR_WIDTH:0] g2b(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchronizer chain: pure flop-to-flop, whole bus sampled on one edge
  logic [ADDR_WIDTH:0] chain_d [SYNC_STAGES];
  logic [ADDR_WIDTH:0] chain_q [SYNC_STAGES];

  always_comb begin
    chain_d[0] = unsync_r_ptr;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      chain_d[k] = chain_q[k-1];
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        chain_q[k] <= '0;
      end
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_gr_r_ptr = chain_q[SYNC_STAGES-1];

  // Decode stage: the borrow of the subtraction is dropped so a wrap still gives the small advance
  logic [ADDR_WIDTH:0] bin_d, bin_q;
  logic [ADDR_WIDTH:0] adv_d, adv_q;
  logic                moved_d, moved_q;

  always_comb begin
    bin_d   = g2b(sync_gr_r_ptr);
    adv_d   = bin_d - bin_q;
    moved_d = (bin_d != bin_q);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      bin_q   <= '0;
      adv_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      adv_q   <= adv_d;
      moved_q <= moved_d;
    end
  end

  assign sync_bin_r_ptr = bin_q;
  assign r_ptr_adv      = adv_q;
  assign r_ptr_moved    = moved_q;

`ifdef W_GRAY_PTR_CHECK_EN
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  // More than one bit set <=> clearing the lowest set bit leaves something behind
  function automatic logic multi_bit(input logic [ADDR_WIDTH:0] x);
    return |(x & (x - 1'b1));
  endfunction

  logic [ADDR_WIDTH:0]      prev_gray_d, prev_gray_q;
  logic                     err_d, err_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                     violation;

  always_comb begin
    prev_gray_d = sync_gr_r_ptr;
    violation   = multi_bit(sync_gr_r_ptr ^ prev_gray_q);
    err_d       = err_q;
    cnt_d       = cnt_q;
    // A violation in the clear cycle wins and restarts the count at one
    if (violation) begin
      err_d = 1'b1;
      if (gray_err_clr) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (gray_err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      prev_gray_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prev_gray_q <= prev_gray_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gray_err     = err_q;
  assign gray_err_cnt = cnt_q;
`else
  logic unused_gray_err_clr;
  assign unused_gray_err_clr = gray_err_clr;
  assign gray_err            = 1'b0;
  assign gray_err_cnt        = '0;
`endif

endmodule
